// File: rtl/ace_snoop_pkg.sv
// ace_snoop_pkg: shared types, widths and mux-select encoding for the snoop line selector.
package ace_snoop_pkg;
    localparam int MUX_SEL_W   = 8;
    localparam int MAX_MASTERS = 8;

    typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_SELECT, S_DELIVER} snoop_sel_state_t;

    // The downstream mux decodes all-zero as master 0.
    function automatic logic [MUX_SEL_W-1:0] enc_mux_sel(input logic [2:0] idx);
        return (idx == 3'd0) ? '0 : MUX_SEL_W'(1) << idx;
    endfunction
endpackage

// File: rtl/snoop_line_sel_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_last+1 with wrap.
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_last,
    output logic [2:0]   o_idx,
    output logic         o_valid
);
    always_comb begin
        int j;
        o_idx   = '0;
        o_valid = |i_req;
        for (int i = N; i >= 1; i--) begin
            j = (int'(i_last) + i) % N;
            if (i_req[j]) o_idx = 3'(j);
        end
    end
endmodule

// File: rtl/snoop_line_sel_ctrl.sv
// snoop_line_sel_ctrl: broadcasts a snoop, collects responses, round-robin selects a data source.
// Optional watchdog enabled by defining SNOOP_TIMEOUT_EN (raises line_err after TIMEOUT_CYCLES in SNOOP).
module snoop_line_sel_ctrl
    import ace_snoop_pkg::*;
#(
    parameter int NUM_MASTERS    = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   snoop_req_valid,
    output logic                   snoop_req_ready,
    input  logic [2:0]             snoop_src_id,
    output logic [NUM_MASTERS-1:0] ac_valid,
    input  logic [NUM_MASTERS-1:0] ac_ready,
    input  logic [NUM_MASTERS-1:0] cr_valid,
    output logic [NUM_MASTERS-1:0] cr_ready,
    input  logic [NUM_MASTERS-1:0] cr_pass_data,
    output logic [MUX_SEL_W-1:0]   mux_sel,
    output logic                   line_valid,
    input  logic                   line_ready,
    output logic                   line_hit,
    output logic                   line_err
);
    snoop_sel_state_t       r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_ac_pend, r_cr_pend, r_data_vec;
    logic [NUM_MASTERS-1:0] w_mask, w_cr_hs, w_ac_nxt, w_cr_nxt;
    logic [2:0]             r_rr_ptr, r_win, w_idx;
    logic [MUX_SEL_W-1:0]   r_mux_sel;
    logic                   r_hit, r_err, w_any, w_tmo;

    // A src id beyond the master count shifts out and excludes nobody.
    assign w_mask   = ~(NUM_MASTERS'(1) << snoop_src_id);
    assign ac_valid = (r_state == S_SNOOP) ? r_ac_pend : '0;
    assign cr_ready = (r_state == S_SNOOP) ? r_cr_pend & ~r_ac_pend : '0;
    assign w_cr_hs  = cr_valid & cr_ready;
    assign w_ac_nxt = r_ac_pend & ~ac_ready;
    assign w_cr_nxt = r_cr_pend & ~w_cr_hs;

    assign snoop_req_ready = (r_state == S_IDLE) && !rst;
    assign line_valid      = (r_state == S_DELIVER);
    assign mux_sel         = r_mux_sel;
    assign line_hit        = r_hit;
    assign line_err        = r_err;

`ifdef SNOOP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    assign w_tmo = (r_state == S_SNOOP) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else     r_cnt <= (r_state == S_SNOOP) ? r_cnt + 1'b1 : '0;
`else
    assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .i_req   (r_data_vec),
        .i_last  (r_rr_ptr),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (snoop_req_valid) w_state_nxt = (|w_mask) ? S_SNOOP : S_SELECT;
            S_SNOOP:   if (w_tmo || (w_ac_nxt == '0 && w_cr_nxt == '0)) w_state_nxt = S_SELECT;
            S_SELECT:  w_state_nxt = S_DELIVER;
            S_DELIVER: if (line_ready) w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ac_pend  <= '0;
            r_cr_pend  <= '0;
            r_data_vec <= '0;
            r_rr_ptr   <= 3'(NUM_MASTERS - 1);
            r_win      <= '0;
            r_mux_sel  <= '0;
            r_hit      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (snoop_req_valid) begin
                    r_ac_pend <= w_mask;
                    r_cr_pend <= w_mask;
                end
                S_SNOOP: begin
                    r_ac_pend  <= w_tmo ? '0 : w_ac_nxt;
                    r_cr_pend  <= w_tmo ? '0 : w_cr_nxt;
                    r_data_vec <= r_data_vec | (cr_pass_data & w_cr_hs);
                    r_err      <= w_tmo;
                end
                S_SELECT: begin
                    r_mux_sel <= w_any ? enc_mux_sel(w_idx) : '0;
                    r_hit     <= w_any;
                    r_win     <= w_idx;
                end
                S_DELIVER: if (line_ready) begin
                    if (r_hit) r_rr_ptr <= r_win;
                    r_data_vec <= '0;
                    r_mux_sel  <= '0;
                    r_hit      <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_line_sel_ctrl.sv
// tb_snoop_line_sel_ctrl: scoreboard bench; expected line results queued at issue, checked at line_valid.
module tb_snoop_line_sel_ctrl;
`ifdef SNOOP_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif
    typedef struct packed {logic [7:0] sel; logic hit; logic err;} exp_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       snoop_req_valid = 1'b0, snoop_req_ready, line_valid, line_ready = 1'b0, line_hit, line_err;
    logic [2:0] snoop_src_id = '0;
    logic [7:0] ac_valid, ac_ready = '1, cr_valid = '1, cr_ready, cr_pass_data = '0, mux_sel;
    exp_t       sb[$];
    int         n_tests = 0, n_fail = 0;

    snoop_line_sel_ctrl #(.NUM_MASTERS(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .snoop_req_valid(snoop_req_valid), .snoop_req_ready(snoop_req_ready),
        .snoop_src_id(snoop_src_id), .ac_valid(ac_valid), .ac_ready(ac_ready), .cr_valid(cr_valid),
        .cr_ready(cr_ready), .cr_pass_data(cr_pass_data), .mux_sel(mux_sel), .line_valid(line_valid),
        .line_ready(line_ready), .line_hit(line_hit), .line_err(line_err)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] src, input logic [7:0] pass, input exp_t e);
        @(negedge clk);
        n_tests++; if (snoop_req_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready got=%b exp=1", snoop_req_ready); end
        snoop_src_id = src; cr_pass_data = pass; snoop_req_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        snoop_req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        exp_t e;
        lat = 1;
        while (line_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
        n_tests++;
        if (line_valid !== 1'b1) begin n_fail++; $display("FAIL line_valid_timeout got=%b exp=1", line_valid); end
        else if (sb.size() == 0) begin n_fail++; $display("FAIL scoreboard_empty got=line_valid exp=none"); end
        else begin
            e = sb.pop_front();
            if ({mux_sel, line_hit, line_err} !== {e.sel, e.hit, e.err}) begin
                n_fail++; $display("FAIL result got sel=%h hit=%b err=%b exp sel=%h hit=%b err=%b", mux_sel, line_hit, line_err, e.sel, e.hit, e.err);
            end
        end
    endtask

    task automatic release_line();
        line_ready = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({snoop_req_ready, ac_valid, cr_ready, mux_sel, line_valid, line_hit, line_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got rdy=%b ac=%h cr=%h sel=%h v=%b h=%b e=%b exp all 0", snoop_req_ready, ac_valid, cr_ready, mux_sel, line_valid, line_hit, line_err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (snoop_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", snoop_req_ready); end
    endtask

    task automatic test_basic();
        int lat;
        issue(3'd2, 8'h20, '{8'h20, 1'b1, 1'b0});
        n_tests++; if (ac_valid !== 8'hFB) begin n_fail++; $display("FAIL basic_ac_valid got=%h exp=fb", ac_valid); end
        wait_valid(lat);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        release_line();
    endtask

    task automatic test_rr();
        int lat;
        apply_reset();
        issue(3'd0, 8'h42, '{8'h02, 1'b1, 1'b0}); wait_valid(lat); release_line();
        issue(3'd0, 8'h42, '{8'h40, 1'b1, 1'b0}); wait_valid(lat); release_line();
    endtask

    task automatic test_m0_and_nohit();
        int lat;
        issue(3'd3, 8'h01, '{8'h00, 1'b1, 1'b0}); wait_valid(lat); release_line();
        issue(3'd0, 8'h00, '{8'h00, 1'b0, 1'b0}); wait_valid(lat); release_line();
    endtask

    task automatic test_delayed();
        int lat;
        ac_ready = 8'h6F;
        issue(3'd0, 8'h10, '{8'h10, 1'b1, 1'b0});
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (ac_valid[4] !== 1'b1 || ac_valid[7] !== 1'b1 || cr_ready[7] !== 1'b0 || line_valid !== 1'b0) begin
                n_fail++; $display("FAIL delayed_hold cyc=%0d got ac=%h cr=%h lv=%b exp ac[4]=1 ac[7]=1 cr[7]=0 lv=0", i, ac_valid, cr_ready, line_valid);
            end
            if (i < 9) @(negedge clk);
        end
        ac_ready = '1;
        @(negedge clk);
        n_tests++; if (ac_valid !== 8'h00) begin n_fail++; $display("FAIL delayed_ac_done got=%h exp=00", ac_valid); end
        wait_valid(lat); release_line();
    endtask

    task automatic test_back_to_back_hold();
        int lat;
        issue(3'd1, 8'h08, '{8'h08, 1'b1, 1'b0});
        wait_valid(lat);
        snoop_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (line_valid !== 1'b1 || mux_sel !== 8'h08 || line_hit !== 1'b1 || snoop_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold cyc=%0d got lv=%b sel=%h hit=%b rdy=%b exp 1 08 1 0", i, line_valid, mux_sel, line_hit, snoop_req_ready);
            end
        end
        snoop_req_valid = 1'b0;
        release_line();
    endtask

    task automatic test_reset_mid();
        int lat;
        ac_ready = '0;
        issue(3'd0, 8'h02, '{8'h00, 1'b0, 1'b0});
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({snoop_req_ready, ac_valid, cr_ready, mux_sel, line_valid, line_hit, line_err} !== '0) begin
            n_fail++; $display("FAIL reset_mid got rdy=%b ac=%h cr=%h sel=%h v=%b exp all 0", snoop_req_ready, ac_valid, cr_ready, mux_sel, line_valid);
        end
        @(negedge clk); rst = 1'b0; sb.delete(); ac_ready = '1;
        issue(3'd2, 8'h22, '{8'h02, 1'b1, 1'b0}); wait_valid(lat); release_line();
    endtask

`ifdef SNOOP_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        cr_valid = 8'hF7;
        issue(3'd0, 8'h20, '{8'h20, 1'b1, 1'b1});
        wait_valid(lat);
        n_tests++; if (lat !== TO + 2) begin n_fail++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TO + 2); end
        release_line();
        cr_valid = '1;
        n_tests++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear got=%b exp=0", line_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rr();
        test_m0_and_nohit();
        test_delayed();
        test_back_to_back_hold();
        test_reset_mid();
`ifdef SNOOP_TIMEOUT_EN
        test_timeout();
`endif
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/snoop_line_sel_ctrl.md
# snoop_line_sel_ctrl

Sequencer for the snoop-data path of the ACE interconnect. It broadcasts a snoop to every master except the initiator and collects each snoop response. It then picks one master that is passing data, using round-robin fairness across transactions. Finally it drives the one-hot select of the downstream cache-line mux and holds it stable for the whole delivery handshake toward the requester.

## Interface
- NUM_MASTERS, 8, number of snooped masters (1..8); mux_sel stays 8 bits wide
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with SNOOP_TIMEOUT_EN
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- snoop_req_valid  input  1  new snoop transaction request
- snoop_req_ready  output  1  controller idle and accepting a request
- snoop_src_id  input  3  initiating master, excluded from the snoop; sampled on request accept
- ac_valid  output  NUM_MASTERS  per-master snoop address valid
- ac_ready  input  NUM_MASTERS  per-master snoop address ready
- cr_valid  input  NUM_MASTERS  per-master snoop response valid
- cr_ready  output  NUM_MASTERS  per-master snoop response ready
- cr_pass_data  input  NUM_MASTERS  response bit: master supplies the line; qualified by cr_valid & cr_ready
- mux_sel  output  8  select for the cache-line mux
- line_valid  output  1  selection result valid
- line_ready  input  1  requester has consumed the result
- line_hit  output  1  a master supplied data; mux_sel is meaningful
- line_err  output  1  watchdog expired; see Configuration

## Operation
- States are IDLE, SNOOP, SELECT and DELIVER.
- **IDLE**
  - snoop_req_ready=1.
  - When snoop_req_valid is also high: target mask = all NUM_MASTERS bits minus bit snoop_src_id (an src id ≥ NUM_MASTERS excludes nothing).
  - ac_pend and cr_pend are loaded with the mask.
  - Go to SNOOP, or to SELECT if the mask is empty.
- **SNOOP**
  - ac_valid=ac_pend. An ac_pend bit clears in the cycle after it is sampled with ac_ready=1.
  - cr_ready = cr_pend & ~ac_pend, so a response is accepted only after its own AC handshake.
  - On cr_valid&cr_ready, the cr_pend bit clears and the pass_data bit is ORed into data_vec.
  - cr_valid on a non-pending bit is ignored.
  - When ac_pend and cr_pend are both zero, go to SELECT.
- **SELECT** (one cycle)
  - Round-robin winner from data_vec. Search starts at rr_ptr+1, wrapping modulo NUM_MASTERS.
  - Winner k drives mux_sel = 8'h00 if k==0, otherwise 1<<k. Master 0 is encoded as all-zero to match the mux decode.
  - line_hit = |data_vec. If there is no hit, mux_sel=8'h00.
  - Go to DELIVER.
- **DELIVER**
  - line_valid=1. mux_sel, line_hit and line_err are held stable.
  - When line_ready=1: rr_ptr=k if there was a hit (unchanged otherwise), data_vec cleared, return to IDLE.
- **Reset mid-transaction:** immediate abort. No response is replayed; masters re-handshake from their own reset.

## Timing
- Reset values: every output 0 (snoop_req_ready=0 while rst is high, then 1 in the first cycle after release); state IDLE, rr_ptr=NUM_MASTERS-1 so master 0 wins first, pending masks and data_vec 0.
- Latency: accept → ac_valid high in the next cycle.
- Last CR accepted → SELECT in the next cycle → line_valid one cycle later.
- With all ready signals held high: accept to line_valid = 4 cycles.
- ac_valid bits never drop without a handshake; cr_ready never rises before that master's AC handshake.
- Multiple CRs in the same cycle are all accepted.
- line_valid holds until line_ready. line_valid and snoop_req_ready are never high together.

## Configuration
- SNOOP_TIMEOUT_EN defined:
  - A counter clears on entering SNOOP and increments each cycle in SNOOP.
  - At count TIMEOUT_CYCLES-1 it forces ac_pend=cr_pend=0 and goes to SELECT with line_err=1.
  - data_vec keeps responses already received, so a hit is still possible.
  - line_err clears on leaving DELIVER.
- SNOOP_TIMEOUT_EN undefined: no counter, line_err tied 0, and SNOOP waits indefinitely.

## Structure
- Package ace_snoop_pkg contains:
  - state enum snoop_sel_state_t;
  - MUX_SEL_W=8 and MAX_MASTERS=8;
  - function enc_mux_sel(idx) returning 8'h00 for 0 and 1<<idx otherwise.
- One sub-module, rr_arbiter (req vector, last pointer → grant index and valid), combinational, instantiated once.

## Test plan
- src=2, all ready high, only m5 passes data → AC to all except m2; mux_sel=8'h20, line_hit=1, line_valid 4 cycles after accept.
- Two transactions in which m1 and m6 both pass data, rr_ptr starting from reset → first mux_sel=8'h02, second 8'h40.
- Only m0 passes data, src=3 → mux_sel=8'h00, line_hit=1. No master passes data → mux_sel=8'h00, line_hit=0.
- ac_ready for m4 delayed 10 cycles, m7 asserts cr_valid before its AC handshake → ac_valid[4] held throughout; cr_ready[7] stays 0 until m7's AC completes; SELECT only after all responses are in.
- line_ready held low for 20 cycles → mux_sel and line_valid stable; a new snoop_req_valid is not accepted. rst pulsed mid-SNOOP → all outputs 0 asynchronously.
- With SNOOP_TIMEOUT_EN and TIMEOUT_CYCLES=16, m3 never responds → line_err=1 at cycle 16 of SNOOP; hits from other masters are retained.
